// File: rtl/imem_sync_if.sv
// Fetch-side bus of imem_sync: read request, read response and the program load port.
// Handshake: a transfer occurs on a rising clk edge where valid && ready are both high; the sender holds valid and payload stable until then.
interface imem_sync_if #(
    parameter int WORDSIZE = 32,
    parameter int AW       = 10
);
    logic                req_valid;
    logic                req_ready;
    logic [31:0]         req_addr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WORDSIZE-1:0] rsp_data;
    logic [1:0]          rsp_err;
    logic                ld_en;
    logic [AW-1:0]       ld_addr;
    logic [WORDSIZE-1:0] ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_sync.sv
// Word-organised instruction memory with a registered, byte-addressed read port,
// configurable wait states, alignment/range fault codes and a run-time load port.
module imem_sync #(
    parameter int    WORDSIZE  = 32,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       rst,
    imem_sync_if.slave bus,
    output logic       busy,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         addr_q;
    logic [WORDSIZE-1:0] rsp_data_q, data_d;
    logic [1:0]          rsp_err_q, err_d;
    logic                accept, capture;
    logic [31:0]         look_addr;

    logic [WORDSIZE-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        accept        = 1'b0;
        capture       = 1'b0;
        bus.req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = !bus.ld_en;
                if (bus.req_valid && !bus.ld_en) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With one-cycle latency the response is captured on the acceptance edge itself,
    // so the lookup must use the incoming address rather than the latched one.
    assign look_addr = (state_q == IDLE) ? bus.req_addr : addr_q;

    always_comb begin
        err_d  = 2'b00;
        data_d = '0;
        if (look_addr[1:0] != 2'b00) begin
            err_d = 2'b01;
        end else if ({2'b00, look_addr[31:2]} >= 32'(DEPTH)) begin
            err_d = 2'b10;
        end else begin
            data_d = mem[look_addr[AW+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) addr_q <= bus.req_addr;
            if (capture) begin
                rsp_data_q <= data_d;
                rsp_err_q  <= err_d;
            end
        end
    end

    // Memory contents survive reset; loads land only while idle.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: a LATENCY=3 instance carries the main directed tests,
// a LATENCY=1 instance covers the single-cycle path and its request spacing.
module tb_imem_sync;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_sync_if #(.WORDSIZE(W), .AW(AW)) b3 ();
    imem_sync_if #(.WORDSIZE(W), .AW(AW)) b1 ();
    logic       busy3, busy1;
    logic [1:0] st3, st1;

    imem_sync #(.WORDSIZE(W), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave), .busy(busy3), .dbg_state(st3)
    );
    imem_sync #(.WORDSIZE(W), .DEPTH(DEPTH), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1), .dbg_state(st1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- scoreboard + monitor, LATENCY=3 instance ----------------
    logic [W+1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           stall_left = 0;
    logic         prev_v3 = 1'b0;
    logic         hs_prev3 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v3  = 1'b0;
            hs_prev3 = 1'b0;
        end else begin
            if (hs_prev3) begin
                chk("req_ready_after_rsp", b3.req_ready, !b3.ld_en);
                chk("busy_after_rsp", busy3, 1'b0);
            end
            hs_prev3 = 1'b0;
            if (b3.rsp_valid) begin
                b3.rsp_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                chk("req_ready_in_resp", b3.req_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_rsp3");
                end else begin
                    if (!prev_v3) chk("rsp_latency3", cyc, exp_cyc_q[0]);
                    chk("rsp_err3", b3.rsp_err, exp_q[0][W+1:W]);
                    chk("rsp_data3", b3.rsp_data, exp_q[0][W-1:0]);
                    if (b3.rsp_ready) begin
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                        hs_prev3 = 1'b1;
                    end
                end
            end else begin
                b3.rsp_ready = 1'b1;
            end
            prev_v3 = b3.rsp_valid;
        end
    end

    // ---------------- scoreboard + monitor, LATENCY=1 instance ----------------
    logic [W+1:0] exp1_q[$];
    int           exp1_cyc_q[$];

    always @(negedge clk) begin
        if (!rst && b1.rsp_valid) begin
            if (exp1_q.size() == 0) begin
                flag_fail("unexpected_rsp1");
            end else begin
                chk("rsp_latency1", cyc, exp1_cyc_q[0]);
                chk("rsp_err1", b1.rsp_err, exp1_q[0][W+1:W]);
                chk("rsp_data1", b1.rsp_data, exp1_q[0][W-1:0]);
                void'(exp1_q.pop_front());
                void'(exp1_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load3(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        b3.ld_en   = 1'b1;
        b3.ld_addr = a;
        b3.ld_data = d;
        #1 chk("req_ready_during_load", b3.req_ready, 1'b0);
        @(negedge clk);
        b3.ld_en = 1'b0;
    endtask

    // Returns on the negedge right after the acceptance edge.
    task automatic read3(input logic [31:0] a, input logic [1:0] e, input logic [W-1:0] d, input int stall);
        int n = 0;
        @(negedge clk);
        b3.req_valid = 1'b1;
        b3.req_addr  = a;
        while (!b3.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            flag_fail("req_accept_timeout3");
        end else begin
            stall_left = stall;
            exp_q.push_back({e, d});
            exp_cyc_q.push_back(cyc + LAT);
        end
        @(negedge clk);
        b3.req_valid = 1'b0;
        b3.req_addr  = '0;
    endtask

    task automatic wait_idle3();
        int n = 0;
        while ((exp_q.size() != 0 || busy3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) flag_fail("idle_timeout3");
    endtask

    task automatic check_after_reset(input string tag);
        chk({tag, "_rsp_valid"}, b3.rsp_valid, 1'b0);
        chk({tag, "_busy"}, busy3, 1'b0);
        chk({tag, "_req_ready"}, b3.req_ready, 1'b1);
    endtask

    task automatic load1(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        b1.ld_en   = 1'b1;
        b1.ld_addr = a;
        b1.ld_data = d;
        @(negedge clk);
        b1.ld_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0]  b2b_addr [4] = '{32'h04, 32'h14, 32'h0C, 32'h06};
    logic [W+1:0] b2b_exp  [4] = '{{2'b00, 32'hA5A50001}, {2'b00, 32'h12345678},
                                   {2'b00, 32'hDEADBEEF}, {2'b01, 32'h0}};
    logic [31:0]  l1_addr  [4] = '{32'h0C, 32'h08, 32'h05, 32'h40};
    logic [W+1:0] l1_exp   [4] = '{{2'b00, 32'hDEADBEEF}, {2'b00, 32'h0BADF00D},
                                   {2'b01, 32'h0}, {2'b10, 32'h0}};
    int           acc [4];

    initial begin
        rst = 1'b1;
        b3.req_valid = 1'b0; b3.req_addr = '0; b3.ld_en = 1'b0; b3.ld_addr = '0; b3.ld_data = '0;
        b1.req_valid = 1'b0; b1.req_addr = '0; b1.ld_en = 1'b0; b1.ld_addr = '0; b1.ld_data = '0;
        b1.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", b3.rsp_valid, 1'b0);
        chk("reset_rsp_data", b3.rsp_data, 32'h0);
        chk("reset_rsp_err", b3.rsp_err, 2'b00);
        chk("reset_busy", busy3, 1'b0);
        chk("reset_state", st3, 2'd0);
        chk("reset_req_ready", b3.req_ready, 1'b1);
        rst = 1'b0;

        load3(4'd1, 32'hA5A50001);
        load3(4'd5, 32'h12345678);
        load3(4'd3, 32'hDEADBEEF);

        read3(32'h04, 2'b00, 32'hA5A50001, 4);   // stalled response
        wait_idle3();
        read3(32'h14, 2'b00, 32'h12345678, 0);
        read3(32'h0C, 2'b00, 32'hDEADBEEF, 0);
        read3(32'h06, 2'b01, 32'h0, 0);
        read3(32'h40, 2'b10, 32'h0, 0);
        read3(32'h42, 2'b01, 32'h0, 0);
        read3(32'h400, 2'b10, 32'h0, 0);
        read3(32'h3C, 2'b00, 32'h0, 0);
        wait_idle3();

        // load while waiting must be dropped
        read3(32'h14, 2'b00, 32'h12345678, 0);
        b3.ld_en = 1'b1; b3.ld_addr = 4'd5; b3.ld_data = 32'hBAD0BAD0;
        repeat (2) @(negedge clk);
        b3.ld_en = 1'b0;
        wait_idle3();
        read3(32'h14, 2'b00, 32'h12345678, 0);
        wait_idle3();

        // reset during WAIT
        read3(32'h04, 2'b00, 32'hA5A50001, 0);
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_after_reset("rst_wait");

        // reset during a stalled RESP
        read3(32'h04, 2'b00, 32'hA5A50001, 10);
        begin
            int n = 0;
            while (!b3.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) flag_fail("rsp_wait_timeout3");
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        stall_left = 0;
        @(negedge clk);
        rst = 1'b0;
        check_after_reset("rst_resp");
        read3(32'h14, 2'b00, 32'h12345678, 0);
        wait_idle3();

        // back-to-back with req_valid held high
        @(negedge clk);
        b3.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!b3.req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) flag_fail("b2b_accept_timeout");
            b3.req_addr = b2b_addr[i];
            exp_q.push_back(b2b_exp[i]);
            exp_cyc_q.push_back(cyc + LAT);
            acc[i] = cyc;
            @(negedge clk);
        end
        b3.req_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing3", acc[i] - acc[i-1], LAT + 1);
        wait_idle3();

        // single-cycle latency instance
        load1(4'd3, 32'hDEADBEEF);
        load1(4'd2, 32'h0BADF00D);
        @(negedge clk);
        b1.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!b1.req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) flag_fail("b2b_accept_timeout1");
            b1.req_addr = l1_addr[i];
            exp1_q.push_back(l1_exp[i]);
            exp1_cyc_q.push_back(cyc + 1);
            acc[i] = cyc;
            @(negedge clk);
        end
        b1.req_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing1", acc[i] - acc[i-1], 2);
        repeat (4) @(negedge clk);
        if (exp1_q.size() != 0) flag_fail("l1_missing_rsp");
        if (exp_q.size() != 0) flag_fail("l3_missing_rsp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
